// File: rtl/sreg_sched.sv
// rtl/sreg_sched.sv - load/shift scheduler for a variable-length left shift register (define SREG_SCHED_RR_EN for round-robin arbitration)
module sreg_sched #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    input  logic [LEN_W-1:0] nbits,
    input  logic [DIV_W-1:0] div,
    input  logic             abort,
    input  logic             ser_in,
    output logic [WIDTH-1:0] sr_pin,
    output logic             sr_load,
    output logic             sr_sft,
    output logic             sr_sin,
    input  logic             sr_sout,
    output logic             ser_data,
    output logic             ser_strobe,
    output logic             busy,
    output logic             gnt_id,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pin_q, pin_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] dcnt_q, dcnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] bcnt_q, bcnt_d;
    logic             gnt_q, gnt_d;
    logic             done_q, done_d;

    logic             idle;
    logic             win1;
    logic             accept;
    logic             strobe;
    logic [LEN_W-1:0] nbits_eff;

    assign idle = (state_q == S_IDLE);

`ifdef SREG_SCHED_RR_EN
    // prio_q names the requester that wins a tie; it starts at req0 after reset.
    logic prio_q, prio_d;

    assign win1   = req1_valid & (~req0_valid | prio_q);
    assign prio_d = (idle & accept) ? ~win1 : prio_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prio_q <= 1'b0;
        else        prio_q <= prio_d;
    end
`else
    assign win1 = req1_valid & ~req0_valid;
`endif

    assign accept     = req0_valid | req1_valid;
    assign req0_ready = idle & req0_valid & ~win1;
    assign req1_ready = idle & win1;

    // Zero or oversize lengths send a full register's worth of bits.
    assign nbits_eff = ((nbits == '0) || (nbits > LEN_W'(WIDTH))) ? LEN_W'(WIDTH) : nbits;

    assign strobe = (state_q == S_SHIFT) && (dcnt_q == '0);

    always_comb begin
        state_d = state_q;
        pin_d   = pin_q;
        div_d   = div_q;
        dcnt_d  = dcnt_q;
        len_d   = len_q;
        bcnt_d  = bcnt_q;
        gnt_d   = gnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    pin_d   = win1 ? req1_data : req0_data;
                    div_d   = div;
                    len_d   = nbits_eff;
                    gnt_d   = win1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                dcnt_d  = div_q;
                bcnt_d  = len_q - LEN_W'(1);
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (strobe) begin
                    dcnt_d = div_q;
                    bcnt_d = bcnt_q - LEN_W'(1);
                    if (bcnt_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    dcnt_d = dcnt_q - DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort wins over a simultaneous last strobe: the frame ends without done.
        if (abort && !idle) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pin_q   <= '0;
            div_q   <= '0;
            dcnt_q  <= '0;
            len_q   <= '0;
            bcnt_q  <= '0;
            gnt_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pin_q   <= pin_d;
            div_q   <= div_d;
            dcnt_q  <= dcnt_d;
            len_q   <= len_d;
            bcnt_q  <= bcnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign sr_pin     = pin_q;
    assign sr_load    = (state_q == S_LOAD);
    assign sr_sft     = strobe;
    assign sr_sin     = ser_in;
    assign ser_strobe = strobe;
    assign ser_data   = strobe & sr_sout;
    assign busy       = ~idle;
    assign gnt_id     = gnt_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sreg_sched.sv
// tb/tb_sreg_sched.sv - directed self-checking bench for sreg_sched
module tb_sreg_sched;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic [4:0]  nbits;
    logic [7:0]  div;
    logic        abort;
    logic        ser_in;
    logic [15:0] sr_pin;
    logic        sr_load, sr_sft, sr_sin, sr_sout;
    logic        ser_data, ser_strobe, busy, gnt_id, done;

    logic [15:0] sr_model;
    int          total;
    int          bad;
    logic        arb_exp [4];

    sreg_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .nbits      (nbits),
        .div        (div),
        .abort      (abort),
        .ser_in     (ser_in),
        .sr_pin     (sr_pin),
        .sr_load    (sr_load),
        .sr_sft     (sr_sft),
        .sr_sin     (sr_sin),
        .sr_sout    (sr_sout),
        .ser_data   (ser_data),
        .ser_strobe (ser_strobe),
        .busy       (busy),
        .gnt_id     (gnt_id),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External left shift register driven by the scheduler.
    always @(posedge clk) begin
        if (sr_load)     sr_model <= sr_pin;
        else if (sr_sft) sr_model <= {sr_model[14:0], sr_sin};
    end
    assign sr_sout = sr_model[15];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle the request is presented; returns in the done cycle.
    task automatic do_frame(input logic v0, input logic v1, input logic exp_id,
                            input logic [15:0] d0, input logic [15:0] d1,
                            input logic [4:0] nb, input logic [7:0] dv, input int n_eff);
        logic [15:0] d;
        d = exp_id ? d1 : d0;
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        nbits = nb; div = dv;
        #1;
        chk("ready_win", exp_id ? req1_ready : req0_ready, 1);
        chk("ready_lose", exp_id ? req0_ready : req1_ready, 0);
        tick();
        req0_valid = 0; req1_valid = 0; abort = 0;
        nbits = 5'd2; div = 8'd7;
        #1;
        chk("load", sr_load, 1);
        chk("load_sft", sr_sft, 0);
        chk("load_busy", busy, 1);
        chk("load_pin", sr_pin, d);
        chk("gnt", gnt_id, exp_id);
        for (int k = 0; k < n_eff; k++) begin
            for (int w = 0; w < dv; w++) begin
                tick(); #1;
                chk("gap_strobe", ser_strobe, 0);
                chk("gap_data", ser_data, 0);
                chk("gap_busy", busy, 1);
            end
            tick(); #1;
            chk("strobe", ser_strobe, 1);
            chk("bit", ser_data, d[15-k]);
            chk("sft", sr_sft, 1);
            chk("no_load", sr_load, 0);
            chk("no_done", done, 0);
        end
        tick(); #1;
        chk("done", done, 1);
        chk("done_busy", busy, 0);
        chk("done_strobe", ser_strobe, 0);
    endtask

    initial begin
        total = 0;
        bad = 0;
`ifdef SREG_SCHED_RR_EN
        arb_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        arb_exp = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        rst_n = 0; req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0;
        nbits = 0; div = 0; abort = 0; ser_in = 0;
        tick(); tick();
        rst_n = 1;
        tick(); #1;
        chk("rst_busy", busy, 0);
        chk("rst_pin", sr_pin, 0);
        chk("rst_strobe", ser_strobe, 0);
        chk("rst_done", done, 0);
        chk("rst_gnt", gnt_id, 0);
        chk("rst_load", sr_load, 0);
        tick();

        do_frame(1, 0, 0, 16'hA5F0, 16'h0000, 5'd16, 8'd0, 16);
        tick();
        do_frame(0, 1, 1, 16'h0000, 16'hC000, 5'd3, 8'd3, 3);
        tick();

        for (int f = 0; f < 4; f++)
            do_frame(1, 1, arb_exp[f], 16'h3C5A, 16'hE718, 5'd2, 8'd1, 2);
        tick();

        do_frame(1, 0, 0, 16'h8001, 16'h0000, 5'd0, 8'd0, 16);
        tick();
        do_frame(1, 0, 0, 16'h1234, 16'h0000, 5'd20, 8'd0, 16);
        tick();

        do_frame(1, 0, 0, 16'h9000, 16'h0000, 5'd4, 8'd1, 4);
        do_frame(1, 0, 0, 16'h6000, 16'h0000, 5'd4, 8'd1, 4);
        tick();

        req0_valid = 1; req0_data = 16'hAAAA; nbits = 5'd16; div = 8'd0;
        #1;
        chk("ab_ready", req0_ready, 1);
        tick();
        req0_valid = 0; #1;
        chk("ab_load", sr_load, 1);
        tick(); #1;
        chk("ab_strobe1", ser_strobe, 1);
        chk("ab_bit1", ser_data, 1);
        tick();
        abort = 1; #1;
        chk("ab_strobe2", ser_strobe, 1);
        chk("ab_bit2", ser_data, 0);
        tick();
        #1;
        chk("ab_after_strobe", ser_strobe, 0);
        chk("ab_after_busy", busy, 0);
        chk("ab_after_done", done, 0);
        do_frame(1, 0, 0, 16'h5000, 16'h0000, 5'd4, 8'd0, 4);
        tick(); #1;
        chk("ab_clear_done", done, 0);

        req1_valid = 1; req1_data = 16'hFFFF; nbits = 5'd8; div = 8'd3;
        tick();
        req1_valid = 0;
        tick(); tick(); tick(); tick(); #1;
        chk("pre_rst_strobe", ser_strobe, 1);
        chk("pre_rst_gnt", gnt_id, 1);
        #1;
        rst_n = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_strobe", ser_strobe, 0);
        chk("arst_data", ser_data, 0);
        chk("arst_sft", sr_sft, 0);
        chk("arst_load", sr_load, 0);
        chk("arst_pin", sr_pin, 0);
        chk("arst_gnt", gnt_id, 0);
        chk("arst_done", done, 0);
        tick(); tick();
        rst_n = 1;
        tick(); #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);
        do_frame(1, 0, 0, 16'hF000, 16'h0000, 5'd2, 8'd2, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
